// File: rtl/vec_lane_demux_if.sv
// Request/lane bus of vec_lane_demux: routed word in, per-lane registers and write pulses out.
interface vec_lane_demux_if #(
  parameter int unsigned N_OUT  = 24,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic [1:0]              in_mode;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic                    busy;
  logic                    err;

  modport master (
    output in_valid, in_data, in_sel, in_mode,
    input  in_ready, out_data, out_valid, busy, err
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_mode,
    output in_ready, out_data, out_valid, busy, err
  );
endinterface

// File: rtl/vec_lane_demux.sv
// Registered 1-to-N_OUT lane demux with single, broadcast and sweep modes.
// out_valid pulses one cycle after each lane register load and serves as its write enable.
module vec_lane_demux #(
  parameter int unsigned N_OUT  = 24,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 5
) (
  input logic             clk,
  input logic             rst_n,
  vec_lane_demux_if.slave bus
);
  localparam int unsigned        CNT_W     = SEL_W + 1;
  localparam logic [CNT_W-1:0]   LANE_LAST = CNT_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0]   LANE_NUM  = CNT_W'(N_OUT);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_data_q;
  logic [N_OUT*DATA_W-1:0] r_lanes;
  logic [N_OUT-1:0]        r_valid;
  logic                    r_err;

  logic                    w_accept;
  logic                    w_sel_ok;
  logic                    w_err;
  logic                    w_sweep_start;
  logic [CNT_W-1:0]        w_sel_ext;
  logic [N_OUT-1:0]        w_we;
  logic [DATA_W-1:0]       w_wdata;

  assign w_sel_ext = CNT_W'(bus.in_sel);
  assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
  assign w_sel_ok  = (w_sel_ext < LANE_NUM);

  // Lane write decode; SWEEP owns the lanes, requests are only seen in IDLE.
  always_comb begin
    w_we          = '0;
    w_wdata       = bus.in_data;
    w_err         = 1'b0;
    w_sweep_start = 1'b0;
    if (r_state == ST_SWEEP) begin
      w_we    = N_OUT'(1) << r_cnt;
      w_wdata = r_data_q;
    end else if (w_accept) begin
      case (bus.in_mode)
        2'b00: begin
          if (w_sel_ok) w_we = N_OUT'(1) << w_sel_ext;
          else          w_err = 1'b1;
        end
        2'b01: w_we = '1;
        2'b10: begin
          if (w_sel_ok) begin
            w_we          = N_OUT'(1) << w_sel_ext;
            w_sweep_start = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // State, counter, held lane registers and one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data_q <= '0;
      r_lanes  <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= w_we;
      r_err   <= w_err;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (w_we[k]) r_lanes[k*DATA_W +: DATA_W] <= w_wdata;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_sweep_start) begin
            r_data_q <= bus.in_data;
            if (w_sel_ext == LANE_LAST) begin
              r_cnt <= w_sel_ext;
            end else begin
              r_cnt   <= w_sel_ext + CNT_W'(1);
              r_state <= ST_SWEEP;
            end
          end
        end
        ST_SWEEP: begin
          // Counter parks on the last lane instead of stepping past it.
          if (r_cnt == LANE_LAST) r_state <= ST_IDLE;
          else                    r_cnt   <= r_cnt + CNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state == ST_SWEEP);
  assign bus.out_data  = r_lanes;
  assign bus.out_valid = r_valid;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_vec_lane_demux.sv
// Directed bench for vec_lane_demux: a 24-lane instance driven from a vector table
// plus hand-written multi-cycle sequences, and a 4-lane instance for the small case.
module tb_vec_lane_demux;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vec_lane_demux_if #(.N_OUT(24), .DATA_W(8), .SEL_W(5)) b24 ();
  vec_lane_demux_if #(.N_OUT(4),  .DATA_W(8), .SEL_W(2)) b4 ();

  vec_lane_demux #(.N_OUT(24), .DATA_W(8), .SEL_W(5)) dut24 (
    .clk(clk), .rst_n(rst_n), .bus(b24)
  );
  vec_lane_demux #(.N_OUT(4), .DATA_W(8), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  sel;
    logic [7:0]  data;
    logic [23:0] exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t         vecs [10];
  logic [191:0] m24;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive24(input logic v, input logic [1:0] m, input logic [4:0] s, input logic [7:0] d);
    b24.in_valid = v;
    b24.in_mode  = m;
    b24.in_sel   = s;
    b24.in_data  = d;
  endtask

  task automatic drive4(input logic v, input logic [1:0] m, input logic [1:0] s, input logic [7:0] d);
    b4.in_valid = v;
    b4.in_mode  = m;
    b4.in_sel   = s;
    b4.in_data  = d;
  endtask

  task automatic chk24(input string name, input logic [23:0] ev, input logic eb, input logic ee);
    chk({name, ".valid"}, 192'(b24.out_valid), 192'(ev));
    chk({name, ".busy"},  192'(b24.busy),      192'(eb));
    chk({name, ".err"},   192'(b24.err),       192'(ee));
    chk({name, ".ready"}, 192'(b24.in_ready),  192'(!eb));
  endtask

  task automatic chk4(input string name, input logic [3:0] ev, input logic eb, input logic ee,
                      input logic [31:0] ed);
    chk({name, ".valid"}, 192'(b4.out_valid), 192'(ev));
    chk({name, ".busy"},  192'(b4.busy),      192'(eb));
    chk({name, ".err"},   192'(b4.err),       192'(ee));
    chk({name, ".ready"}, 192'(b4.in_ready),  192'(!eb));
    chk({name, ".data"},  192'(b4.out_data),  192'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    drive4(1'b0, 2'b00, 2'd0, 8'h00);
    m24 = '0;

    // Reset held for two cycles
    rst_n = 1'b0;
    step();
    step();
    chk24("reset", 24'h0, 1'b0, 1'b0);
    chk("reset.data24", 192'(b24.out_data), 192'(0));
    chk4("reset4", 4'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    vecs[0] = '{2'b00, 5'd5,  8'hA5, 24'h000020, 1'b0};
    vecs[1] = '{2'b01, 5'd0,  8'h3C, 24'hFFFFFF, 1'b0};
    vecs[2] = '{2'b00, 5'd0,  8'h11, 24'h000001, 1'b0};
    vecs[3] = '{2'b00, 5'd23, 8'hC3, 24'h800000, 1'b0};
    vecs[4] = '{2'b00, 5'd24, 8'hEE, 24'h000000, 1'b1};
    vecs[5] = '{2'b11, 5'd3,  8'hEE, 24'h000000, 1'b1};
    vecs[6] = '{2'b01, 5'd31, 8'h5A, 24'hFFFFFF, 1'b0};
    vecs[7] = '{2'b10, 5'd31, 8'h77, 24'h000000, 1'b1};
    vecs[8] = '{2'b00, 5'd31, 8'h66, 24'h000000, 1'b1};
    vecs[9] = '{2'b00, 5'd12, 8'h99, 24'h001000, 1'b0};

    // Back-to-back single/broadcast/error requests, one per cycle
    for (int i = 0; i < 10; i++) begin
      drive24(1'b1, vecs[i].mode, vecs[i].sel, vecs[i].data);
      step();
      for (int k = 0; k < 24; k++) begin
        if (vecs[i].exp_valid[k]) m24[k*8 +: 8] = vecs[i].data;
      end
      chk24($sformatf("vec%0d", i), vecs[i].exp_valid, 1'b0, vecs[i].exp_err);
      chk($sformatf("vec%0d.data", i), 192'(b24.out_data), m24);
    end
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    step();
    chk24("idle_after_vecs", 24'h0, 1'b0, 1'b0);

    // Sweep from lane 20; a request raised mid-sweep must be ignored
    drive24(1'b1, 2'b10, 5'd20, 8'h7E);
    step();
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    chk24("sweep20.c1", 24'h100000, 1'b1, 1'b0);
    step();
    chk24("sweep20.c2", 24'h200000, 1'b1, 1'b0);
    drive24(1'b1, 2'b00, 5'd2, 8'hFF);
    step();
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    chk24("sweep20.c3", 24'h400000, 1'b1, 1'b0);
    step();
    chk24("sweep20.c4", 24'h800000, 1'b0, 1'b0);
    for (int k = 20; k < 24; k++) m24[k*8 +: 8] = 8'h7E;
    chk("sweep20.data", 192'(b24.out_data), m24);
    step();
    chk24("sweep20.c5", 24'h0, 1'b0, 1'b0);

    // One-lane sweep from the last lane
    drive24(1'b1, 2'b10, 5'd23, 8'h42);
    step();
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    m24[23*8 +: 8] = 8'h42;
    chk24("sweep23.c1", 24'h800000, 1'b0, 1'b0);
    chk("sweep23.data", 192'(b24.out_data), m24);
    step();
    chk24("sweep23.c2", 24'h0, 1'b0, 1'b0);

    // Reset in the middle of a sweep from lane 0
    drive24(1'b1, 2'b10, 5'd0, 8'h5C);
    step();
    drive24(1'b0, 2'b00, 5'd0, 8'h00);
    chk24("rsweep.c1", 24'h000001, 1'b1, 1'b0);
    step();
    chk24("rsweep.c2", 24'h000002, 1'b1, 1'b0);
    step();
    step();
    chk24("rsweep.c4", 24'h000008, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m24 = '0;
    chk24("rsweep.rst", 24'h0, 1'b0, 1'b0);
    chk("rsweep.data", 192'(b24.out_data), m24);
    step();
    chk24("rsweep.after1", 24'h0, 1'b0, 1'b0);
    step();
    chk24("rsweep.after2", 24'h0, 1'b0, 1'b0);
    chk("rsweep.data2", 192'(b24.out_data), m24);

    // Four-lane instance: single, sweep, one-lane sweep, reserved mode
    drive4(1'b1, 2'b00, 2'd2, 8'h81);
    step();
    drive4(1'b0, 2'b00, 2'd0, 8'h00);
    chk4("n4.single", 4'b0100, 1'b0, 1'b0, 32'h0081_0000);
    drive4(1'b1, 2'b10, 2'd1, 8'h6D);
    step();
    drive4(1'b0, 2'b00, 2'd0, 8'h00);
    chk4("n4.sweep.c1", 4'b0010, 1'b1, 1'b0, 32'h0081_6D00);
    step();
    chk4("n4.sweep.c2", 4'b0100, 1'b1, 1'b0, 32'h006D_6D00);
    step();
    chk4("n4.sweep.c3", 4'b1000, 1'b0, 1'b0, 32'h6D6D_6D00);
    drive4(1'b1, 2'b10, 2'd3, 8'h3E);
    step();
    drive4(1'b0, 2'b00, 2'd0, 8'h00);
    chk4("n4.sweep3", 4'b1000, 1'b0, 1'b0, 32'h3E6D_6D00);
    drive4(1'b1, 2'b11, 2'd1, 8'hAA);
    step();
    drive4(1'b0, 2'b00, 2'd0, 8'h00);
    chk4("n4.err", 4'b0000, 1'b0, 1'b1, 32'h3E6D_6D00);
    step();
    chk4("n4.idle", 4'b0000, 1'b0, 1'b0, 32'h3E6D_6D00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vec_lane_demux.md
Name: vec_lane_demux

Overview:
- Parametrised, registered successor of the 1-to-24 demux; routes one DATA_W-bit word to one, all, or a contiguous run of N_OUT lane registers.
- Sits between the vector decode stage and the per-lane register write ports; the out_valid pulses act as per-lane write enables.
- Adds a valid/ready handshake, broadcast and sweep modes, an out-of-range error flag, and held lane data.

Parameters:
N_OUT, 24, number of output lanes (2..32)
DATA_W, 8, width of the routed word and of each lane register
SEL_W, 5, select width; must equal $clog2(N_OUT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  request present
in_ready  out  1  block can accept a request this cycle
in_data  in  DATA_W  word to route
in_sel  in  SEL_W  target lane (single) or start lane (sweep)
in_mode  in  2  00 single, 01 broadcast, 10 sweep, 11 reserved
out_data  out  N_OUT*DATA_W  lane registers; lane k is bits [k*DATA_W +: DATA_W]
out_valid  out  N_OUT  one-cycle write pulse per lane
busy  out  1  high while in SWEEP
err  out  1  one-cycle pulse for a rejected request

Behaviour:
- Reset: rst_n low at a clk edge sets state IDLE, all out_data 0, out_valid 0, err 0, busy 0, and the counter to 0. Reset dominates every other input; a reset during SWEEP aborts the sweep with no further writes.
- in_ready = (state == IDLE), combinational from state only. A request is accepted when in_valid && in_ready at a clk edge.
- All outputs are registered. out_valid and err are 0 on every cycle with no new write or error.
- Lane registers not written in a cycle hold their value.
- Single mode (00, in_sel < N_OUT):
  - At the accept edge, lane in_sel loads in_data.
  - In the next cycle, out_valid has only bit in_sel set. Latency is 1 cycle.
- Broadcast mode (01): in_sel is ignored. At the accept edge, all lanes load in_data; out_valid is all ones for 1 cycle.
- Sweep mode (10, in_sel < N_OUT):
  - At the accept edge, lane in_sel loads in_data, data_q captures in_data, and cnt is set to in_sel+1.
  - If in_sel == N_OUT-1, state stays IDLE (one-lane sweep). Otherwise state goes to SWEEP.
  - Each SWEEP edge loads lane cnt with data_q, pulses out_valid[cnt] in the next cycle, and increments cnt.
  - On the edge where cnt == N_OUT-1, state returns to IDLE.
  - Lane k (k >= in_sel) is valid in cycle k-in_sel+1 after the accept edge.
  - busy is high exactly in the SWEEP cycles; in_ready is low then. in_valid in SWEEP is ignored (not accepted, no error).
  - A new request is accepted on the first cycle back in IDLE.
- Error cases:
  - Rejected requests: in_mode 11, or in_sel >= N_OUT in single or sweep mode.
  - The request is accepted (consumed) but writes no lane. err = 1 for the following cycle; out_valid = 0 in that cycle.
  - Broadcast never errors.
- The counter is SEL_W+1 bits wide internally and never wraps past N_OUT-1. No lane index >= N_OUT is ever written.
- Back-to-back single or broadcast requests are accepted every cycle (throughput 1/cycle in IDLE).

Test Plan:
- Reset, then single: hold rst_n=0 for 2 cycles -> out_data all 0, out_valid 0, in_ready 1. Then in_mode=00, in_sel=5, in_data=0xA5 -> next cycle out_valid=24'h000020, lane5=0xA5, all other lanes 0.
- Broadcast, then single: in_mode=01, in_data=0x3C -> out_valid=24'hFFFFFF for 1 cycle, all lanes 0x3C. Next, single sel=0 data=0x11 -> lane0=0x11, lanes1..23 remain 0x3C.
- Sweep from 20: in_mode=10, in_sel=20, in_data=0x7E -> lanes 20,21,22,23 pulse in cycles 1..4 and load 0x7E. busy is high in cycles 1..3 and in_ready low then. A request with in_valid=1 at cycle 2 is not accepted and causes no error.
- One-lane sweep: in_sel=23, in_mode=10 -> out_valid[23] for 1 cycle, busy never asserts, in_ready stays 1.
- Errors: in_mode=00, in_sel=24 -> err=1 for 1 cycle, out_valid=0, lanes unchanged. Same result for in_mode=11, in_sel=3.
- Reset mid-sweep: start sweep at in_sel=0, drop rst_n in cycle 4 -> next cycle all lanes 0, busy 0, in_ready 1, no further out_valid pulses. Repeat the single/sweep cases with N_OUT=4, SEL_W=2.
